// File: rtl/sn_stream_decoder.sv
// Stochastic bitstream decoder: counts ones over a 2^win window and presents
// count / bipolar results through a valid/ready register. Optional: SN_BIPOLAR_EN.
module sn_stream_decoder #(
    parameter int unsigned WIN_LOG2_MAX = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sn_bit,
    input  logic                    sn_valid,
    input  logic [3:0]              win_log2,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [WIN_LOG2_MAX:0]   out_count,
    output logic [WIN_LOG2_MAX+1:0] out_bipolar,
    output logic [3:0]              out_win,
    output logic                    overrun
);

    localparam int unsigned CW = WIN_LOG2_MAX + 1;
    localparam int unsigned BW = WIN_LOG2_MAX + 2;
    localparam int unsigned WW = 4;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACC  = 1'b1
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_acc, w_acc_nxt;
    logic [CW-1:0]   r_seen, w_seen_nxt;
    logic [WW-1:0]   r_win, w_win_nxt;
    logic            r_out_valid, w_out_valid_nxt;
    logic [CW-1:0]   r_out_count, w_out_count_nxt;
    logic [WW-1:0]   r_out_win, w_out_win_nxt;
    logic            r_overrun, w_overrun_nxt;

    logic [WW-1:0]   w_win_clamped;
    logic [CW-1:0]   w_final;
    logic            w_last;
    logic            w_done;
    logic            w_load;

    // Window exponent as it would be latched this cycle.
    always_comb begin
        w_win_clamped = win_log2;
        if (win_log2 == WW'(0)) begin
            w_win_clamped = WW'(1);
        end else if (win_log2 > WW'(WIN_LOG2_MAX)) begin
            w_win_clamped = WW'(WIN_LOG2_MAX);
        end
    end

    assign w_final = r_acc + CW'(sn_bit);
    assign w_last  = (r_seen + CW'(1)) == (CW'(1) << r_win);
    assign w_done  = (r_state == S_ACC) && sn_valid && w_last;
    assign w_load  = w_done && (!r_out_valid || out_ready);

    // Next-state and result-register logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_seen_nxt      = r_seen;
        w_win_nxt       = r_win;
        w_out_valid_nxt = r_out_valid;
        w_out_count_nxt = r_out_count;
        w_out_win_nxt   = r_out_win;
        w_overrun_nxt   = r_overrun;

        case (r_state)
            S_IDLE: begin
                if (sn_valid) begin
                    w_win_nxt   = w_win_clamped;
                    w_acc_nxt   = CW'(sn_bit);
                    w_seen_nxt  = CW'(1);
                    w_state_nxt = S_ACC;
                end
            end
            S_ACC: begin
                if (sn_valid) begin
                    if (w_last) begin
                        // Restart in the completion cycle so no bit is lost.
                        w_acc_nxt  = '0;
                        w_seen_nxt = '0;
                        w_win_nxt  = w_win_clamped;
                    end else begin
                        w_acc_nxt  = w_final;
                        w_seen_nxt = r_seen + CW'(1);
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_load) begin
            w_out_valid_nxt = 1'b1;
            w_out_count_nxt = w_final;
            w_out_win_nxt   = r_win;
        end else if (r_out_valid && out_ready) begin
            w_out_valid_nxt = 1'b0;
        end

        if (w_done && !w_load) begin
            w_overrun_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_seen      <= '0;
            r_win       <= '0;
            r_out_valid <= 1'b0;
            r_out_count <= '0;
            r_out_win   <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_seen      <= w_seen_nxt;
            r_win       <= w_win_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_count <= w_out_count_nxt;
            r_out_win   <= w_out_win_nxt;
            r_overrun   <= w_overrun_nxt;
        end
    end

`ifdef SN_BIPOLAR_EN
    logic [BW-1:0] r_out_bipolar;
    logic [BW-1:0] w_bipolar;

    assign w_bipolar = {w_final, 1'b0} - (BW'(1) << r_win);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_out_bipolar <= '0;
        end else if (w_load) begin
            r_out_bipolar <= w_bipolar;
        end
    end

    assign out_bipolar = r_out_bipolar;
`else
    assign out_bipolar = BW'(0);
`endif

    assign out_valid = r_out_valid;
    assign out_count = r_out_count;
    assign out_win   = r_out_win;
    assign overrun   = r_overrun;

endmodule

// File: doc/sn_stream_decoder.md
# sn_stream_decoder

Downstream decode stage for the stochastic datapath. It consumes the serial stochastic bitstream produced by the XNOR multiplier stage. It counts ones over a programmable power-of-two window and presents each window's result through a valid/ready output register. Results are given both as a raw ones count and as a bipolar signed value (2·count − N).

## Interface
- `WIN_LOG2_MAX`, default 8: largest supported window exponent; window length N = 2^win, win ∈ [1, WIN_LOG2_MAX].
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  synchronous, active-high reset: 1 = reset, sampled on `clk`.
- `sn_bit`  in  1  stochastic bit.
- `sn_valid`  in  1  `sn_bit` is sampled only when high.
- `win_log2`  in  4  requested window exponent; latched at window start.
- `out_ready`  in  1  consumer accepts the result.
- `out_valid`  out  1  result register holds an unaccepted result.
- `out_count`  out  WIN_LOG2_MAX+1  ones in the window, 0..2^win.
- `out_bipolar`  out  WIN_LOG2_MAX+2  signed two's complement, 2·count − 2^win.
- `out_win`  out  4  window exponent used for the presented result.
- `overrun`  out  1  sticky; a completed result was dropped.

## Operation
- State machine:
  - IDLE (entered on reset): wait for the first `sn_valid`.
  - On that bit: latch `win_log2` (clamped), set acc = `sn_bit`, set seen = 1, go to ACC.
  - ACC: on each `sn_valid`, acc += `sn_bit` and seen += 1.
- Window completion occurs on the `sn_valid` cycle where seen + 1 == 2^win:
  - final = acc + `sn_bit`.
  - Result is offered to the output register.
  - Same cycle: the window restarts with acc = 0, seen = 0, and `win_log2` is re-latched. No bit is lost and the FSM never returns to IDLE.
- Clamp rules on latching `win_log2`:
  - 0 → 1.
  - Greater than WIN_LOG2_MAX → WIN_LOG2_MAX.
  - Mid-window changes are ignored until the next window.
- Widths:
  - acc and seen are WIN_LOG2_MAX+1 bits; no wrap is possible.
  - Bipolar value = (final << 1) − (1 << win), computed at WIN_LOG2_MAX+2 bits.
- Output register load:
  - Loads when `out_valid`==0, or when `out_valid`&&`out_ready` in the same cycle.
  - Otherwise the new result is discarded, the held result is kept unchanged, and `overrun` is set to 1.
- `overrun` clears only on reset.
- Handshake:
  - Transfer occurs on `out_valid`&&`out_ready`.
  - Once asserted, `out_valid` stays high and data stays stable until transfer.
  - Acceptance and a new completion in the same cycle: new data loads and `out_valid` remains 1.
- `sn_valid`=0 cycles freeze acc, seen and the FSM.

## Timing
- Reset values:
  - `out_valid`=0, `out_count`=0, `out_bipolar`=0, `out_win`=0, `overrun`=0.
  - FSM = IDLE, acc = 0, seen = 0.
- Latency: `out_valid` rises on the clock edge after the edge that sampled a window's last bit (1 cycle).
- Throughput: one bit per cycle; with `out_ready` held at 1, a result is produced every 2^win valid bits with no stall.
- Reset asserted mid-window: the partial window and any held result are discarded; next cycle is IDLE with all outputs at reset values.
- Reset has priority over all other events in the same cycle.

## Configuration
- `SN_BIPOLAR_EN` defined: `out_bipolar` is computed and registered as above.
- `SN_BIPOLAR_EN` undefined:
  - No bipolar logic is built.
  - `out_bipolar` is tied to 0.
  - `out_count`, `out_win` and the handshake are unchanged.

## Test plan
- Reset, `win_log2`=3, `out_ready`=1, 8 cycles of `sn_valid`=1 with `sn_bit`=1 → one-cycle `out_valid` pulse one cycle after the 8th bit; `out_count`=8, `out_bipolar`=+8, `out_win`=3.
- `win_log2`=4, bits 1010… for 16 valid cycles, then all-0 for 16 → results count=8/bipolar=0, then count=0/bipolar=−16; back-to-back with no lost bits.
- `sn_valid` toggling every other cycle, `win_log2`=2, all ones → completion after the 4th valid bit (8th cycle); `out_count`=4.
- `out_ready`=0, `win_log2`=1, stream 11 then 00 → `out_valid` held with count=2; second window sets `overrun`=1 and `out_count` stays 2. Raising `out_ready` → transfer, then `out_valid`=0; `overrun` stays 1.
- `win_log2`=0 → 2-bit windows; `win_log2`=15 → 256-bit windows. Change 3→2 mid-window → current window still completes at 8 bits, next window at 4.
- Assert `rst_n`=1 after 5 of 8 bits → all outputs 0 next cycle; the subsequent 8 bits produce a full fresh result with no carry-over.
